// File: rtl/run_monitor_pkg.sv
// -----------------------------------------------------------------------------
// run_monitor_pkg
// Shared types and constants for the run_monitor block.
//   runmon_state_t : encoding of the run-control FSM, also driven onto the
//                    2-bit state output (00 IDLE, 01 RUN, 10 DONE).
//   runmon_cause_t : why a run ended on the current edge (NONE when it did not).
//   RUNMON_PASS_DEFAULT / RUNMON_FAIL_DEFAULT : default watched end values.
// -----------------------------------------------------------------------------
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } runmon_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_PASS,
    CAUSE_FAIL,
    CAUSE_TIMEOUT
  } runmon_cause_t;

  localparam logic [31:0] RUNMON_PASS_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] RUNMON_FAIL_DEFAULT = 32'hDEAD_BEEF;

endpackage : run_monitor_pkg

// File: rtl/run_monitor_counter.sv
// -----------------------------------------------------------------------------
// run_monitor_counter
// Saturating up-counter used for every run_monitor statistic.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset (clears the count)
//   clr   : synchronous clear, takes priority over inc
//   inc   : count enable; the count sticks at all-ones instead of wrapping
//   count : current value
// -----------------------------------------------------------------------------
module run_monitor_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : run_monitor_counter

// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
// Run-control and end-of-test monitor sitting between the test harness and the
// core. Releases the core while in RUN, counts run cycles and memory
// handshakes, and ends the run on a pass value, a fail value or a cycle limit
// (pass beats fail beats timeout when several hit on the same edge).
//
// Optional feature macro: RUNMON_STALL_CNT_EN
//   defined   : Stall counts RUN cycles with fetch Ready=1 and Valid=0.
//   undefined : no stall counter; RUNMON_Stall_OutBUS is tied to 0.
//
// Ports
//   RUNMON_Clk_In            clock, rising edge
//   RUNMON_Reset_In          synchronous active-high reset
//   RUNMON_Start_In          start/restart request (honoured in IDLE and DONE)
//   RUNMON_Limit_InBUS       cycle limit latched at start, 0 = unlimited
//   RUNMON_Watch_InBUS       watched register value
//   RUNMON_Insmem_*          fetch handshake
//   RUNMON_Datamem_Ready/Valid load handshake
//   RUNMON_Datamem_Wvalid/Wready store handshake
//   RUNMON_Core_Run_Out      high only in RUN (core runs while high)
//   RUNMON_State_OutBUS      00 IDLE, 01 RUN, 10 DONE
//   RUNMON_Done/Pass/Fail/Timeout_Out  registered status flags
//   RUNMON_*_OutBUS          cycle / fetch / load / store / stall counters
// -----------------------------------------------------------------------------
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int                   DATAWIDTH  = 32,
  parameter int                   CNT_WIDTH  = 32,
  parameter logic [DATAWIDTH-1:0] PASS_VALUE = DATAWIDTH'(RUNMON_PASS_DEFAULT),
  parameter logic [DATAWIDTH-1:0] FAIL_VALUE = DATAWIDTH'(RUNMON_FAIL_DEFAULT)
) (
  input  logic                 RUNMON_Clk_In,
  input  logic                 RUNMON_Reset_In,
  input  logic                 RUNMON_Start_In,
  input  logic [CNT_WIDTH-1:0] RUNMON_Limit_InBUS,
  input  logic [DATAWIDTH-1:0] RUNMON_Watch_InBUS,
  input  logic                 RUNMON_Insmem_Ready_In,
  input  logic                 RUNMON_Insmem_Valid_In,
  input  logic                 RUNMON_Datamem_Ready_In,
  input  logic                 RUNMON_Datamem_Valid_In,
  input  logic                 RUNMON_Datamem_Wvalid_In,
  input  logic                 RUNMON_Datamem_Wready_In,
  output logic                 RUNMON_Core_Run_Out,
  output logic [1:0]           RUNMON_State_OutBUS,
  output logic                 RUNMON_Done_Out,
  output logic                 RUNMON_Pass_Out,
  output logic                 RUNMON_Fail_Out,
  output logic                 RUNMON_Timeout_Out,
  output logic [CNT_WIDTH-1:0] RUNMON_Cycles_OutBUS,
  output logic [CNT_WIDTH-1:0] RUNMON_Fetch_OutBUS,
  output logic [CNT_WIDTH-1:0] RUNMON_Load_OutBUS,
  output logic [CNT_WIDTH-1:0] RUNMON_Store_OutBUS,
  output logic [CNT_WIDTH-1:0] RUNMON_Stall_OutBUS
);

  runmon_state_t        state_q, state_d;
  runmon_cause_t        cause;
  logic [CNT_WIDTH-1:0] limit_q;
  logic [CNT_WIDTH-1:0] cycles_plus_one;
  logic                 in_run, start_accept;
  logic                 done_q, pass_q, fail_q, timeout_q, core_run_q;
  logic                 done_d, pass_d, fail_d, timeout_d, core_run_d;

  assign in_run       = (state_q == ST_RUN);
  assign start_accept = RUNMON_Start_In && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // ---------------------------------------------------------------------------
  // State register (also holds the registered status outputs and the limit)
  // ---------------------------------------------------------------------------
  always_ff @(posedge RUNMON_Clk_In) begin
    if (RUNMON_Reset_In) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      core_run_q <= 1'b0;
      limit_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      core_run_q <= core_run_d;
      if (start_accept) begin
        limit_q <= RUNMON_Limit_InBUS;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // End-condition priority. The timeout compares against the count this edge
  // will produce, so a limit of L ends the run with Cycles == L.
  // ---------------------------------------------------------------------------
  assign cycles_plus_one = RUNMON_Cycles_OutBUS + 1'b1;

  // NOTE: every signal assigned in an always_comb block gets a default first,
  // so no path through the block can infer a latch.
  always_comb begin
    cause = CAUSE_NONE;
    if (in_run) begin
      if (RUNMON_Watch_InBUS == PASS_VALUE) begin
        cause = CAUSE_PASS;
      end else if (RUNMON_Watch_InBUS == FAIL_VALUE) begin
        cause = CAUSE_FAIL;
      end else if ((limit_q != '0) && (cycles_plus_one == limit_q)) begin
        cause = CAUSE_TIMEOUT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (RUNMON_Start_In) state_d = ST_RUN;
      ST_RUN:  if (cause != CAUSE_NONE) state_d = ST_DONE;
      ST_DONE: if (RUNMON_Start_In) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Flags hold in DONE,
  // clear on an accepted start and get exactly one cause bit on termination.
  // ---------------------------------------------------------------------------
  always_comb begin
    done_d     = (state_d == ST_DONE);
    core_run_d = (state_d == ST_RUN);
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    if (start_accept) begin
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (cause)
        CAUSE_PASS:    pass_d    = 1'b1;
        CAUSE_FAIL:    fail_d    = 1'b1;
        CAUSE_TIMEOUT: timeout_d = 1'b1;
        default:       ;
      endcase
    end
  end

  assign RUNMON_State_OutBUS = state_q;
  assign RUNMON_Core_Run_Out = core_run_q;
  assign RUNMON_Done_Out     = done_q;
  assign RUNMON_Pass_Out     = pass_q;
  assign RUNMON_Fail_Out     = fail_q;
  assign RUNMON_Timeout_Out  = timeout_q;

  // ---------------------------------------------------------------------------
  // Counters: cleared on an accepted start, advance only on RUN edges.
  // ---------------------------------------------------------------------------
  run_monitor_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk   (RUNMON_Clk_In),
    .rst   (RUNMON_Reset_In),
    .clr   (start_accept),
    .inc   (in_run),
    .count (RUNMON_Cycles_OutBUS)
  );

  run_monitor_counter #(.WIDTH(CNT_WIDTH)) u_fetch (
    .clk   (RUNMON_Clk_In),
    .rst   (RUNMON_Reset_In),
    .clr   (start_accept),
    .inc   (in_run && RUNMON_Insmem_Ready_In && RUNMON_Insmem_Valid_In),
    .count (RUNMON_Fetch_OutBUS)
  );

  run_monitor_counter #(.WIDTH(CNT_WIDTH)) u_load (
    .clk   (RUNMON_Clk_In),
    .rst   (RUNMON_Reset_In),
    .clr   (start_accept),
    .inc   (in_run && RUNMON_Datamem_Ready_In && RUNMON_Datamem_Valid_In),
    .count (RUNMON_Load_OutBUS)
  );

  run_monitor_counter #(.WIDTH(CNT_WIDTH)) u_store (
    .clk   (RUNMON_Clk_In),
    .rst   (RUNMON_Reset_In),
    .clr   (start_accept),
    .inc   (in_run && RUNMON_Datamem_Wvalid_In && RUNMON_Datamem_Wready_In),
    .count (RUNMON_Store_OutBUS)
  );

`ifdef RUNMON_STALL_CNT_EN
  // Fetch port ready but the core not requesting: counted as a stall cycle.
  run_monitor_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk   (RUNMON_Clk_In),
    .rst   (RUNMON_Reset_In),
    .clr   (start_accept),
    .inc   (in_run && RUNMON_Insmem_Ready_In && !RUNMON_Insmem_Valid_In),
    .count (RUNMON_Stall_OutBUS)
  );
`else
  assign RUNMON_Stall_OutBUS = '0;
`endif

endmodule : run_monitor

// File: tb/tb_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_run_monitor
// Directed testbench for run_monitor: reset, pass / fail / timeout runs,
// end-condition priority, handshake counting, restart and mid-run reset.
// -----------------------------------------------------------------------------
module tb_run_monitor;

  localparam int CW = 32;
  localparam logic [31:0] PASS_V = 32'hFFFF_FFFF;
  localparam logic [31:0] FAIL_V = 32'hDEAD_BEEF;

`ifdef RUNMON_STALL_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [CW-1:0] limit;
  logic [31:0]   watch;
  logic          i_rdy, i_vld, d_rdy, d_vld, w_vld, w_rdy;
  logic          core_run, done, pass, fail, timeout;
  logic [1:0]    state;
  logic [CW-1:0] cycles, fetch, load, store, stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_monitor dut (
    .RUNMON_Clk_In            (clk),
    .RUNMON_Reset_In          (rst),
    .RUNMON_Start_In          (start),
    .RUNMON_Limit_InBUS       (limit),
    .RUNMON_Watch_InBUS       (watch),
    .RUNMON_Insmem_Ready_In   (i_rdy),
    .RUNMON_Insmem_Valid_In   (i_vld),
    .RUNMON_Datamem_Ready_In  (d_rdy),
    .RUNMON_Datamem_Valid_In  (d_vld),
    .RUNMON_Datamem_Wvalid_In (w_vld),
    .RUNMON_Datamem_Wready_In (w_rdy),
    .RUNMON_Core_Run_Out      (core_run),
    .RUNMON_State_OutBUS      (state),
    .RUNMON_Done_Out          (done),
    .RUNMON_Pass_Out          (pass),
    .RUNMON_Fail_Out          (fail),
    .RUNMON_Timeout_Out       (timeout),
    .RUNMON_Cycles_OutBUS     (cycles),
    .RUNMON_Fetch_OutBUS      (fetch),
    .RUNMON_Load_OutBUS       (load),
    .RUNMON_Store_OutBUS      (store),
    .RUNMON_Stall_OutBUS      (stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [CW-1:0] lim);
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic p, input logic f, input logic t,
                           input int cyc);
    check({tag, "_state"},   state,    2'b10);
    check({tag, "_done"},    done,     1'b1);
    check({tag, "_run"},     core_run, 1'b0);
    check({tag, "_pass"},    pass,     p);
    check({tag, "_fail"},    fail,     f);
    check({tag, "_timeout"}, timeout,  t);
    check({tag, "_cycles"},  cycles,   cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; limit = '0; watch = '0;
    i_rdy = 0; i_vld = 0; d_rdy = 0; d_vld = 0; w_vld = 0; w_rdy = 0;

    // Reset
    tick(2);
    check("rst_state",   state,    2'b00);
    check("rst_run",     core_run, 1'b0);
    check("rst_flags",   {done, pass, fail, timeout}, 4'b0000);
    check("rst_cycles",  cycles, 0);
    check("rst_cnts",    {fetch, load, store, stall}, 128'h0);
    rst = 1'b0;
    tick();
    check("idle_hold", state, 2'b00);

    // Pass run: watch hits on the 100th RUN edge
    start_run(5000);
    check("pass_state_run", state,    2'b01);
    check("pass_core_run",  core_run, 1'b1);
    check("pass_cyc0",      cycles,   0);
    tick(99);
    check("pass_cyc99", cycles, 99);
    watch = PASS_V;
    tick();
    watch = '0;
    check_end("pass", 1'b1, 1'b0, 1'b0, 100);
    tick(3);
    check("pass_hold_cyc",  cycles, 100);
    check("pass_hold_flag", pass,   1'b1);

    // Timeout with limit 10; a limit change after start must be ignored
    start_run(10);
    check("to_clear_pass", pass,   1'b0);
    check("to_clear_cyc",  cycles, 0);
    limit = 3;
    tick(9);
    check("to_still_run", state, 2'b01);
    tick();
    check_end("to", 1'b0, 1'b0, 1'b1, 10);

    // Unlimited run
    start_run(0);
    tick(20000);
    check("nolim_state",  state,  2'b01);
    check("nolim_done",   done,   1'b0);
    check("nolim_cycles", cycles, 20000);

    // Start in RUN is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_state", state,  2'b01);
    check("start_in_run_cyc",   cycles, 20001);
    watch = FAIL_V;
    tick();
    watch = '0;
    check_end("fail", 1'b0, 1'b1, 1'b0, 20002);

    // Pass and timeout on the same edge: pass wins; cycles restart from 1
    start_run(10);
    tick();
    check("restart_cyc1",  cycles, 1);
    check("restart_state", state,  2'b01);
    tick(8);
    watch = PASS_V;
    tick();
    watch = '0;
    check_end("sim_pass", 1'b1, 1'b0, 1'b0, 10);

    // Fail and timeout on the same edge: fail wins
    start_run(10);
    tick(9);
    watch = FAIL_V;
    tick();
    watch = '0;
    check_end("sim_fail", 1'b0, 1'b1, 1'b0, 10);

    // Handshakes in DONE are not counted
    i_rdy = 1; i_vld = 1; d_rdy = 1; d_vld = 1; w_vld = 1; w_rdy = 1;
    tick(2);
    check("done_no_cnt", {fetch, load, store}, 96'h0);

    // Handshake counting: 16 RUN cycles, last one also ends the run with pass
    start_run(0);
    for (int i = 0; i < 16; i++) begin
      i_rdy = (i < 10);
      i_vld = (i < 7);
      d_rdy = (i == 10) || (i == 11) || (i == 12);
      d_vld = (i == 10) || (i == 11) || (i == 13);
      w_vld = (i >= 12) || (i == 5);
      w_rdy = (i >= 12);
      watch = (i == 15) ? PASS_V : '0;
      tick();
    end
    watch = '0;
    check("hs_fetch", fetch, 7);
    check("hs_load",  load,  2);
    check("hs_store", store, 4);
    check("hs_stall", stall, EXP_STALL);
    check_end("hs", 1'b1, 1'b0, 1'b0, 16);
    i_rdy = 1; i_vld = 1;
    tick(2);
    check("hs_done_hold", fetch, 7);
    i_rdy = 0; i_vld = 0; d_rdy = 0; d_vld = 0; w_vld = 0; w_rdy = 0;

    // Reset mid-run at cycle 50
    start_run(0);
    i_rdy = 1; i_vld = 1;
    tick(50);
    check("mid_cyc50",  cycles, 50);
    check("mid_fetch",  fetch,  50);
    rst = 1'b1;
    tick();
    check("mid_state",  state,    2'b00);
    check("mid_run",    core_run, 1'b0);
    check("mid_cycles", cycles,   0);
    check("mid_fetch0", fetch,    0);
    rst = 1'b0; i_rdy = 0; i_vld = 0;
    tick(2);
    check("mid_idle_hold", {state, cycles}, 34'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_run_monitor

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control and end-of-test monitor that sits between the test harness and `CORE`. It releases the core, counts run cycles and memory handshakes, and stops the run on one of three conditions: the watched register reaching a pass value, reaching a fail value, or hitting a programmable cycle limit. It reports status and counters as registered outputs, so a bench or an on-chip debug port can read results without hierarchical probing.

## Interface
Parameters:
- `DATAWIDTH`, 32, width of the watched register bus.
- `CNT_WIDTH`, 32, width of every counter and of the limit bus.
- `PASS_VALUE`, 32'hFFFFFFFF, watched value that ends the run with pass.
- `FAIL_VALUE`, 32'hDEADBEEF, watched value that ends the run with fail.

Ports:
- `RUNMON_Clk_In`  in  1  single clock; all logic is on the rising edge.
- `RUNMON_Reset_In`  in  1  synchronous, active-high reset.
- `RUNMON_Start_In`  in  1  start or restart request, sampled in IDLE and DONE.
- `RUNMON_Limit_InBUS`  in  CNT_WIDTH  cycle limit, latched at start; 0 means no limit.
- `RUNMON_Watch_InBUS`  in  DATAWIDTH  watched register (x31).
- `RUNMON_Insmem_Ready_In`, `RUNMON_Insmem_Valid_In`  in  1 each  fetch handshake.
- `RUNMON_Datamem_Ready_In`, `RUNMON_Datamem_Valid_In`  in  1 each  load handshake.
- `RUNMON_Datamem_Wvalid_In`, `RUNMON_Datamem_Wready_In`  in  1 each  store handshake.
- `RUNMON_Core_Run_Out`  out  1  high only in RUN; drives the core's reset input (core runs while high).
- `RUNMON_State_OutBUS`  out  2  00 IDLE, 01 RUN, 10 DONE.
- `RUNMON_Done_Out`, `RUNMON_Pass_Out`, `RUNMON_Fail_Out`, `RUNMON_Timeout_Out`  out  1 each  status flags.
- `RUNMON_Cycles_OutBUS`, `RUNMON_Fetch_OutBUS`, `RUNMON_Load_OutBUS`, `RUNMON_Store_OutBUS`, `RUNMON_Stall_OutBUS`  out  CNT_WIDTH each  counters.

## Operation
- **Reset values:** state IDLE, every flag 0, every counter 0, `RUNMON_Core_Run_Out` 0, latched limit 0.
- **IDLE → RUN:** taken on Start = 1. Counters clear, flags clear, limit latches.
- **RUN, every edge:**
  - Cycles increments.
  - Fetch increments on Insmem Ready & Valid.
  - Load increments on Datamem Ready & Valid.
  - Store increments on Wvalid & Wready.
- **RUN end conditions**, evaluated on the same edge, in priority order:
  1. Watch == PASS_VALUE → DONE with Pass = 1.
  2. Watch == FAIL_VALUE → DONE with Fail = 1.
  3. Limit ≠ 0 and Cycles + 1 == Limit → DONE with Timeout = 1.
- **Exclusivity:** exactly one of Pass, Fail or Timeout is set in DONE. Done = 1 throughout DONE.
- **DONE:** counters and flags hold. Start = 1 clears them and re-enters RUN on the same edge.
- **Start in RUN:** ignored.
- **Counter overflow:** every counter saturates at all-ones and never wraps.
- **Reset mid-run:** returns to IDLE, counters cleared, core released to reset immediately.

## Timing
- All outputs are registered.
- Start sampled at edge N → State = RUN and Core_Run_Out = 1 after edge N.
- Termination on edge M → State = DONE, Done = 1, Core_Run_Out = 0 after edge M.
- Cycles includes the terminating edge. With limit L and no watch hit, Cycles = L.
- Handshakes occurring on the terminating edge are counted. Handshakes outside RUN are not counted.
- Watch is compared on raw input at the edge; there is no input pipelining.

## Configuration
- `RUNMON_STALL_CNT_EN` defined: Stall counts RUN cycles with Insmem Ready = 1 and Valid = 0, with the same clear and saturation rules as the other counters.
- Not defined: the Stall counter logic is absent and `RUNMON_Stall_OutBUS` is tied to 0. The port list is unchanged.

## Structure
- Package `run_monitor_pkg`:
  - state enum `runmon_state_t` (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10);
  - end-cause enum (NONE, PASS, FAIL, TIMEOUT);
  - default PASS/FAIL constants.
- Sub-module `run_monitor_counter`: CNT_WIDTH saturating counter with synchronous clear and increment enable, instantiated once per counter.
- FSM and end-condition priority logic live in `run_monitor`.

## Test plan
- **Reset:** assert reset for 2 cycles → State = 00, all flags 0, all counters 0, Core_Run_Out = 0.
- **Pass run:** Limit = 5000, Watch = FFFFFFFF presented on the 100th RUN edge → Done = 1, Pass = 1, Cycles = 100, Core_Run_Out = 0 the next cycle.
- **Timeout:** Limit = 10, Watch held at 0 → Timeout = 1, Cycles = 10. Then Limit = 0 for 20000 cycles → still RUN.
- **Simultaneous events:** Limit = 10, Watch = FFFFFFFF on the 10th edge → Pass = 1, Timeout = 0.
  - Watch = FAIL_VALUE on the same edge instead → Fail = 1.
- **Handshake counting:** 7 fetch handshakes, 3 Ready-without-Valid cycles, 2 loads, 4 stores → Fetch = 7, Load = 2, Store = 4.
  - Stall = 3 with `RUNMON_STALL_CNT_EN` defined, 0 without.
- **Reset mid-run and restart:**
  - Reset at cycle 50 of a run → IDLE, counters 0.
  - Start in DONE → RUN next cycle, Cycles restarts from 1.
  - Start pulsed in RUN → no effect.
